hood_time_scheduler: RTL and testbench
======================================

// Module: hood_time_scheduler
// PURPOSE
//  Timing and sequencing controller for the range-hood display datapath. Generates the
//  1 Hz tick and maintains the current time (hours/minutes/seconds) and the cleaning
//  reminder state that feed the seven-segment driver. Handles setting of the current time.
//  Sequences the auto-clean countdown and clears accumulated work time when a clean completes.
// PARAMETERS
//  CLK_HZ        100_000_000  clk cycles per 1 Hz tick (bench uses 4)
//  AUTO_CLEAN_S  180          auto-clean duration in seconds (1..255)
//  WORK_UNIT_S   3600         work seconds per work_hours increment (bench uses 5)
// PORTS
//  clk              in   1  system clock
//  reset            in   1  synchronous, active-high reset
//  power_state      in   1  1 = ON, 0 = OFF
//  mode_state       in   4  0 MENU, 1/2/3 gears, 4 AUTO_CLEAN, 5 MANUAL_CLEAN, 6 QUERY, 7 SET_CURRENT_TIME
//  key_sel          in   1  1-cycle pulse: advance the field being set
//  key_up           in   1  1-cycle pulse: increment the selected field
//  key_down         in   1  1-cycle pulse: decrement the selected field
//  work_limit       in   7  reminder threshold in work_hours; 0 disables the reminder
//  hours            out  5  current hour, 0..23
//  minutes          out  6  current minute, 0..59
//  seconds          out  6  current second, 0..59
//  sel_field        out  2  0 = HOUR, 1 = MIN, 2 = SEC (field being set)
//  work_hours       out  7  accumulated gear work units, saturates at 127
//  clean_reminder   out  1  work_limit != 0 && work_hours >= work_limit (combinational)
//  clean_remaining  out  8  auto-clean seconds left; 0 when not counting
//  clean_done       out  1  1-cycle pulse when a clean completes
//  tick_1hz         out  1  1-cycle pulse every CLK_HZ cycles
// BEHAVIOUR
//  Reset: all registered outputs and counters are 0; sel_field = HOUR; clean FSM = IDLE.
//  Divider: counts 0..CLK_HZ-1. tick_1hz = 1 on the cycle the count is CLK_HZ-1. The
//    divider runs regardless of power_state and mode.
//  Time: advances on tick_1hz, also when power_state is OFF. The only exception is
//    mode SET_CURRENT_TIME with power ON, where time is frozen and the tick is ignored.
//    Carry chain: 59 s -> 0 s with minute+1; 59 min -> 0 with hour+1; 23:59:59 -> 00:00:00.
//  Set: active only in SET_CURRENT_TIME with power ON.
//    - key_sel cycles sel_field HOUR -> MIN -> SEC -> HOUR.
//    - key_up / key_down change only the selected field, with wrap and no carry:
//      hours 23 <-> 0, minutes/seconds 59 <-> 0.
//    - key_up and key_down in the same cycle: no change.
//    - Key changes apply on the next clock edge.
//    - Entering the mode resets sel_field to HOUR.
//    - Keys in any other mode are ignored.
//  Work: with power ON and mode 1..3, each tick increments work_sec. When work_sec
//    reaches WORK_UNIT_S-1 on a tick, work_sec -> 0 and work_hours -> work_hours+1,
//    saturating at 127. No accumulation in any other mode or with power OFF.
//  Clean FSM (states IDLE, COUNTING, DONE):
//    IDLE -> COUNTING: mode == AUTO_CLEAN and power ON; clean_remaining <= AUTO_CLEAN_S.
//    COUNTING: each tick decrements clean_remaining. A tick with clean_remaining == 1
//      -> DONE: clean_remaining <= 0, clean_done pulses 1 cycle, work_sec and
//      work_hours clear.
//    COUNTING -> IDLE: mode leaves AUTO_CLEAN or power OFF; clean_remaining <= 0, no
//      clear. Abort takes priority over a tick in the same cycle.
//    DONE -> IDLE: mode != AUTO_CLEAN. While in DONE, no restart.
//    MANUAL_CLEAN: the cycle after mode changes into 5 with power ON, work counters
//      clear and clean_done pulses once. Staying in mode 5 does not pulse again.
//  Reset mid-operation: returns to reset values in one cycle; any countdown is discarded.
// TESTING
//  CLK_HZ=4, WORK_UNIT_S=5, AUTO_CLEAN_S=3 unless stated.
//  1 Set 23:59:58, mode 0 -> after 2 ticks 00:00:00; tick_1hz period exactly 4 clk.
//  2 Mode 7: key_sel x1, key_down at min=0 -> min=59, hour unchanged; up+down together
//    -> no change; 8 idle cycles -> seconds frozen.
//  3 Mode 1 for 10 ticks -> work_hours=2; work_limit=2 -> clean_reminder=1; work_limit=0
//    -> clean_reminder=0.
//  4 Mode 4 -> clean_remaining 3,2,1; clean_done pulses 1 cycle on the 3rd tick;
//    work_hours=0; no re-trigger while mode stays 4.
//  5 Mode 4, switch to mode 0 after 1 tick -> clean_remaining=0, no clean_done,
//    work_hours kept.
//  6 Assert reset during COUNTING and during set -> next cycle all outputs 0,
//    sel_field=HOUR.

Source files
------------

// File: rtl/hood_time_scheduler_if.sv
// Purpose : Bundles the control inputs and display outputs of the range-hood
//           time scheduler so that they travel as one port.
// Signals : i_* are driven by the controller side (power, mode, keys, work
//           limit); o_* are driven by the scheduler (current time, field being
//           set, work hours, reminder, clean countdown, clean done, 1 Hz tick).
// Modports: slave  - scheduler side (takes i_*, drives o_*)
//           master - controller / display side (drives i_*, takes o_*)
interface hood_time_scheduler_if;
  logic       i_power_state;
  logic [3:0] i_mode_state;
  logic       i_key_sel;
  logic       i_key_up;
  logic       i_key_down;
  logic [6:0] i_work_limit;
  logic [4:0] o_hours;
  logic [5:0] o_minutes;
  logic [5:0] o_seconds;
  logic [1:0] o_sel_field;
  logic [6:0] o_work_hours;
  logic       o_clean_reminder;
  logic [7:0] o_clean_remaining;
  logic       o_clean_done;
  logic       o_tick_1hz;

  modport slave (
    input  i_power_state, i_mode_state, i_key_sel, i_key_up, i_key_down, i_work_limit,
    output o_hours, o_minutes, o_seconds, o_sel_field, o_work_hours,
           o_clean_reminder, o_clean_remaining, o_clean_done, o_tick_1hz
  );

  modport master (
    output i_power_state, i_mode_state, i_key_sel, i_key_up, i_key_down, i_work_limit,
    input  o_hours, o_minutes, o_seconds, o_sel_field, o_work_hours,
           o_clean_reminder, o_clean_remaining, o_clean_done, o_tick_1hz
  );
endinterface

// File: rtl/hood_time_scheduler.sv
// Purpose : Timing and sequencing controller for the range-hood display.
//           Divides clk down to a 1 Hz tick, keeps the time of day, lets the
//           user set the time, accumulates gear work time, drives the cleaning
//           reminder and sequences the auto-clean countdown.
// Ports   : i_clk   - system clock
//           i_reset - synchronous, active-high reset
//           bus     - hood_time_scheduler_if.slave (mode/power/keys/work limit in,
//                     time, sel field, work hours, reminder, clean status, tick out)
module hood_time_scheduler #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int AUTO_CLEAN_S = 180,
  parameter int WORK_UNIT_S  = 3600
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  hood_time_scheduler_if.slave  bus
);

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int WS_W  = (WORK_UNIT_S > 1) ? $clog2(WORK_UNIT_S) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_HZ - 1);
  localparam logic [WS_W-1:0]  WS_MAX    = WS_W'(WORK_UNIT_S - 1);
  localparam logic [7:0]       AUTO_LOAD = 8'(AUTO_CLEAN_S);

  localparam logic [3:0] MODE_GEAR_LO = 4'd1;
  localparam logic [3:0] MODE_GEAR_HI = 4'd3;
  localparam logic [3:0] MODE_AUTO    = 4'd4;
  localparam logic [3:0] MODE_MANUAL  = 4'd5;
  localparam logic [3:0] MODE_SET     = 4'd7;

  localparam logic [1:0] SEL_HOUR = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_SEC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_DONE     = 2'd2
  } clean_state_t;

  // Step a field by one with wrap-around and no carry (max_val <-> 0).
  function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                           input logic [5:0] max_val,
                                           input logic       up);
    if (up) begin
      return (val == max_val) ? 6'd0 : val + 6'd1;
    end else begin
      return (val == 6'd0) ? max_val : val - 6'd1;
    end
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_hours;
  logic [5:0]       r_minutes;
  logic [5:0]       r_seconds;
  logic [1:0]       r_sel;
  logic             r_set_prev;
  logic [WS_W-1:0]  r_work_sec;
  logic [6:0]       r_work_hours;
  logic [7:0]       r_remaining;
  logic             r_clean_done;
  logic [3:0]       r_mode_prev;
  clean_state_t     r_state;

  logic w_tick;
  logic w_set_active;
  logic w_gear;
  logic w_auto_req;
  logic w_manual_entry;

  assign w_tick         = (r_div == DIV_MAX);
  assign w_set_active   = bus.i_power_state && (bus.i_mode_state == MODE_SET);
  assign w_gear         = bus.i_power_state && (bus.i_mode_state >= MODE_GEAR_LO) &&
                          (bus.i_mode_state <= MODE_GEAR_HI);
  assign w_auto_req     = bus.i_power_state && (bus.i_mode_state == MODE_AUTO);
  // Manual clean fires only on the transition into the mode, not while staying in it.
  assign w_manual_entry = bus.i_power_state && (bus.i_mode_state == MODE_MANUAL) &&
                          (r_mode_prev != MODE_MANUAL);

  // 1 Hz divider: free-running regardless of power and mode.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Time of day: set keys while in set mode (time frozen), otherwise tick with carry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hours    <= 5'd0;
      r_minutes  <= 6'd0;
      r_seconds  <= 6'd0;
      r_sel      <= SEL_HOUR;
      r_set_prev <= 1'b0;
    end else begin
      r_set_prev <= w_set_active;
      if (w_set_active) begin
        if (!r_set_prev) begin
          // Entry cycle: always start editing at HOUR; keys in this cycle are dropped.
          r_sel <= SEL_HOUR;
        end else begin
          if (bus.i_key_sel) begin
            r_sel <= (r_sel == SEL_SEC) ? SEL_HOUR : r_sel + 2'd1;
          end
          // Up and down together cancel out.
          if (bus.i_key_up ^ bus.i_key_down) begin
            case (r_sel)
              SEL_HOUR: r_hours   <= 5'(wrap_step({1'b0, r_hours}, 6'd23, bus.i_key_up));
              SEL_MIN:  r_minutes <= wrap_step(r_minutes, 6'd59, bus.i_key_up);
              SEL_SEC:  r_seconds <= wrap_step(r_seconds, 6'd59, bus.i_key_up);
              default:  r_sel     <= SEL_HOUR;
            endcase
          end
        end
      end else if (w_tick) begin
        if (r_seconds == 6'd59) begin
          r_seconds <= 6'd0;
          if (r_minutes == 6'd59) begin
            r_minutes <= 6'd0;
            r_hours   <= (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
          end else begin
            r_minutes <= r_minutes + 6'd1;
          end
        end else begin
          r_seconds <= r_seconds + 6'd1;
        end
      end
    end
  end

  // Clean FSM with work accumulation; a completed clean overrides accumulation.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_remaining  <= 8'd0;
      r_clean_done <= 1'b0;
      r_work_sec   <= '0;
      r_work_hours <= 7'd0;
      r_mode_prev  <= 4'd0;
    end else begin
      r_mode_prev  <= bus.i_mode_state;
      r_clean_done <= 1'b0;
      if (w_gear && w_tick) begin
        if (r_work_sec == WS_MAX) begin
          r_work_sec <= '0;
          if (r_work_hours != 7'd127) begin
            r_work_hours <= r_work_hours + 7'd1;
          end
        end else begin
          r_work_sec <= r_work_sec + WS_W'(1);
        end
      end
      if (w_manual_entry) begin
        r_work_sec   <= '0;
        r_work_hours <= 7'd0;
        r_clean_done <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_auto_req) begin
            r_state     <= ST_COUNTING;
            r_remaining <= AUTO_LOAD;
          end
        end
        ST_COUNTING: begin
          // Abort is checked before the tick so it wins in the same cycle.
          if (!w_auto_req) begin
            r_state     <= ST_IDLE;
            r_remaining <= 8'd0;
          end else if (w_tick) begin
            if (r_remaining == 8'd1) begin
              r_state      <= ST_DONE;
              r_remaining  <= 8'd0;
              r_clean_done <= 1'b1;
              r_work_sec   <= '0;
              r_work_hours <= 7'd0;
            end else begin
              r_remaining <= r_remaining - 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (bus.i_mode_state != MODE_AUTO) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_remaining <= 8'd0;
        end
      endcase
    end
  end

  assign bus.o_hours           = r_hours;
  assign bus.o_minutes         = r_minutes;
  assign bus.o_seconds         = r_seconds;
  assign bus.o_sel_field       = r_sel;
  assign bus.o_work_hours      = r_work_hours;
  assign bus.o_clean_remaining = r_remaining;
  assign bus.o_clean_done      = r_clean_done;
  assign bus.o_tick_1hz        = w_tick;
  assign bus.o_clean_reminder  = (bus.i_work_limit != 7'd0) && (r_work_hours >= bus.i_work_limit);

endmodule

// File: tb/tb_hood_time_scheduler.sv
// Purpose : Self-checking bench for hood_time_scheduler. A behavioural model keeps
//           the time as seconds-of-day and work as total gear seconds, and every
//           cycle the DUT outputs are compared against it. Directed scenarios also
//           compare against hand-derived constants, then a randomized phase runs.
module tb_hood_time_scheduler;
  localparam int CLK_HZ = 4;
  localparam int AUTO_S = 3;
  localparam int UNIT_S = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hood_time_scheduler_if bus();

  hood_time_scheduler #(
    .CLK_HZ(CLK_HZ), .AUTO_CLEAN_S(AUTO_S), .WORK_UNIT_S(UNIT_S)
  ) dut (
    .i_clk(clk), .i_reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_div, m_tod, m_sel, m_work, m_cst, m_rem, m_mode_prev;
  bit m_set_prev, m_done;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_wh();
    return (m_work / UNIT_S > 127) ? 127 : m_work / UNIT_S;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int h, mi, s, d, mode;
    bit tick, pw, set_act, auto_req;
    if (reset) begin
      m_div = 0; m_tod = 0; m_sel = 0; m_work = 0; m_cst = 0; m_rem = 0;
      m_mode_prev = 0; m_set_prev = 0; m_done = 0;
      return;
    end
    pw   = bus.i_power_state;
    mode = int'(bus.i_mode_state);
    tick = (m_div == CLK_HZ - 1);
    m_div = (m_div + 1) % CLK_HZ;
    set_act = pw && mode == 7;
    if (set_act) begin
      if (!m_set_prev) m_sel = 0;
      else begin
        h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
        if (bus.i_key_up != bus.i_key_down) begin
          d = bus.i_key_up ? 1 : -1;
          case (m_sel)
            0: h = (h + d + 24) % 24;
            1: mi = (mi + d + 60) % 60;
            2: s = (s + d + 60) % 60;
            default: ;
          endcase
          m_tod = h * 3600 + mi * 60 + s;
        end
        if (bus.i_key_sel) m_sel = (m_sel + 1) % 3;
      end
    end else if (tick) m_tod = (m_tod + 1) % 86400;
    m_set_prev = set_act;
    m_done = 0;
    if (pw && mode >= 1 && mode <= 3 && tick) m_work++;
    if (pw && mode == 5 && m_mode_prev != 5) begin m_work = 0; m_done = 1; end
    auto_req = pw && mode == 4;
    case (m_cst)
      0: if (auto_req) begin m_cst = 1; m_rem = AUTO_S; end
      1: begin
        if (!auto_req) begin m_cst = 0; m_rem = 0; end
        else if (tick) begin
          m_rem--;
          if (m_rem == 0) begin m_cst = 2; m_done = 1; m_work = 0; end
        end
      end
      2: if (mode != 4) m_cst = 0;
      default: m_cst = 0;
    endcase
    m_mode_prev = mode;
  endtask

  task automatic compare_all();
    int lim;
    lim = int'(bus.i_work_limit);
    chk("hours", int'(bus.o_hours), m_tod / 3600);
    chk("minutes", int'(bus.o_minutes), (m_tod / 60) % 60);
    chk("seconds", int'(bus.o_seconds), m_tod % 60);
    chk("sel_field", int'(bus.o_sel_field), m_sel);
    chk("work_hours", int'(bus.o_work_hours), m_wh());
    chk("clean_reminder", int'(bus.o_clean_reminder), (lim != 0 && m_wh() >= lim) ? 1 : 0);
    chk("clean_remaining", int'(bus.o_clean_remaining), m_rem);
    chk("clean_done", int'(bus.o_clean_done), int'(m_done));
    chk("tick_1hz", int'(bus.o_tick_1hz), (m_div == CLK_HZ - 1) ? 1 : 0);
  endtask

  // One clock: model step, edge, sample #1 later, then release key pulses.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    bus.i_key_sel = 1'b0; bus.i_key_up = 1'b0; bus.i_key_down = 1'b0;
  endtask

  // Run until n ticks have been applied by the DUT (bounded); returns ticks applied.
  task automatic run_ticks(input int n, output int applied);
    bit t;
    applied = 0;
    for (int k = 0; k < n * CLK_HZ + 8 && applied < n; k++) begin
      t = bus.o_tick_1hz;
      cycle();
      if (t) applied++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hours"}, int'(bus.o_hours), 0);
    chk({tag, "_minutes"}, int'(bus.o_minutes), 0);
    chk({tag, "_seconds"}, int'(bus.o_seconds), 0);
    chk({tag, "_sel"}, int'(bus.o_sel_field), 0);
    chk({tag, "_work"}, int'(bus.o_work_hours), 0);
    chk({tag, "_rem"}, int'(bus.o_clean_remaining), 0);
    chk({tag, "_done"}, int'(bus.o_clean_done), 0);
    chk({tag, "_tick"}, int'(bus.o_tick_1hz), 0);
  endtask

  initial begin
    int applied, n, dones, wh_before, ticks_in;
    bit t;
    reset = 1'b1;
    bus.i_power_state = 1'b0; bus.i_mode_state = 4'd0;
    bus.i_key_sel = 1'b0; bus.i_key_up = 1'b0; bus.i_key_down = 1'b0;
    bus.i_work_limit = 7'd0;
    cycle(); cycle();
    chk_all_zero("reset");
    reset = 1'b0;

    // Scenario 2: set mode, minute wrap down, up+down no-op, frozen time
    bus.i_power_state = 1'b1; bus.i_mode_state = 4'd7;
    cycle();
    bus.i_key_sel = 1'b1; cycle();
    chk("set_sel_min", int'(bus.o_sel_field), 1);
    bus.i_key_down = 1'b1; cycle();
    chk("set_min_wrap", int'(bus.o_minutes), 59);
    chk("set_hour_kept", int'(bus.o_hours), 0);
    bus.i_key_up = 1'b1; bus.i_key_down = 1'b1; cycle();
    chk("set_updown_min", int'(bus.o_minutes), 59);
    repeat (8) cycle();
    chk("set_frozen_sec", int'(bus.o_seconds), 0);
    bus.i_key_sel = 1'b1; cycle();
    bus.i_key_down = 1'b1; cycle();
    bus.i_key_down = 1'b1; cycle();
    bus.i_key_sel = 1'b1; cycle();
    bus.i_key_down = 1'b1; cycle();
    chk("set_23", int'(bus.o_hours), 23);
    chk("set_58", int'(bus.o_seconds), 58);

    // Scenario 1: rollover and tick period
    bus.i_mode_state = 4'd0;
    run_ticks(2, applied);
    chk("roll_ticks", applied, 2);
    chk("roll_h", int'(bus.o_hours), 0);
    chk("roll_m", int'(bus.o_minutes), 0);
    chk("roll_s", int'(bus.o_seconds), 0);
    n = 0;
    while (!bus.o_tick_1hz && n < 10) begin cycle(); n++; end
    n = 0;
    do begin cycle(); n++; end while (!bus.o_tick_1hz && n < 10);
    chk("tick_period", n, CLK_HZ);

    // Scenario 3: work accumulation and reminder
    reset = 1'b1; cycle(); reset = 1'b0;
    bus.i_mode_state = 4'd1;
    run_ticks(10, applied);
    bus.i_mode_state = 4'd0;
    cycle();
    chk("work_2", int'(bus.o_work_hours), 2);
    bus.i_work_limit = 7'd2; #1;
    chk("reminder_on", int'(bus.o_clean_reminder), 1);
    bus.i_work_limit = 7'd0; #1;
    chk("reminder_off", int'(bus.o_clean_reminder), 0);

    // Scenario 4: auto clean completes
    bus.i_mode_state = 4'd4;
    cycle();
    chk("auto_load", int'(bus.o_clean_remaining), 3);
    dones = 0; ticks_in = 0;
    for (int k = 0; k < 30 && dones == 0; k++) begin
      t = bus.o_tick_1hz;
      cycle();
      if (t) ticks_in++;
      if (bus.o_clean_done) dones++;
    end
    chk("auto_ticks", ticks_in, 3);
    chk("auto_work_clr", int'(bus.o_work_hours), 0);
    repeat (14) begin cycle(); if (bus.o_clean_done) dones++; end
    chk("auto_one_pulse", dones, 1);
    chk("auto_no_restart", int'(bus.o_clean_remaining), 0);

    // Scenario 5: abort keeps work
    bus.i_mode_state = 4'd2;
    run_ticks(5, applied);
    wh_before = int'(bus.o_work_hours);
    chk("abort_pre_work", wh_before, 1);
    bus.i_mode_state = 4'd4;
    cycle();
    run_ticks(1, applied);
    chk("abort_rem2", int'(bus.o_clean_remaining), 2);
    bus.i_mode_state = 4'd0;
    cycle();
    chk("abort_rem0", int'(bus.o_clean_remaining), 0);
    chk("abort_done", int'(bus.o_clean_done), 0);
    chk("abort_work", int'(bus.o_work_hours), 1);

    // Scenario 6: reset while counting and while setting
    bus.i_mode_state = 4'd4;
    repeat (3) cycle();
    reset = 1'b1; cycle();
    chk_all_zero("rst_count");
    reset = 1'b0;
    bus.i_mode_state = 4'd7;
    cycle();
    bus.i_key_sel = 1'b1; cycle();
    bus.i_key_sel = 1'b1; cycle();
    chk("rst_set_pre", int'(bus.o_sel_field), 2);
    reset = 1'b1; cycle();
    chk_all_zero("rst_set");
    reset = 1'b0;

    // Randomized phase against the model
    bus.i_mode_state = 4'd1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.i_mode_state = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 60) == 0) bus.i_power_state = ~bus.i_power_state;
      if ($urandom_range(0, 40) == 0) bus.i_work_limit = 7'($urandom_range(0, 4));
      bus.i_key_sel  = ($urandom_range(0, 3) == 0);
      bus.i_key_up   = ($urandom_range(0, 2) == 0);
      bus.i_key_down = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 400) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
